syscall_ctrl: RTL

- Consumes the two register-file read ports at the execute stage of the single-cycle CPU. On a syscall, the register file presents $v0 on port A and $a0 on port B; this block interprets them.
- Drives the PC-enable gate (halt/resume), the LED display latch and the run statistics counters.
- Resume comes from the board GO button, synchronised internally.

---
 rtl/syscall_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/syscall_ctrl.sv
// syscall_ctrl: execute-stage syscall interpreter for the single-cycle CPU.
//   Halt/resume control of the PC-enable gate, LED display latch and
//   run statistics counters. GO button is synchronised internally.
// Ports:
//   in_clk, in_rst        clock, async active-high reset
//   in_syscall            current instruction is SYSCALL
//   in_A / in_B           register-file ports ($v0 / $a0 during a syscall)
//   in_go                 asynchronous GO button level
//   out_pc_en             PC / architectural write enable
//   out_halted            1 while halted
//   out_led               display value
//   out_icount            retired-instruction counter
//   out_sccount           accepted-syscall counter
module syscall_ctrl #(
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter logic [31:0] DISP_CODE = 32'd34,
    parameter int          CNT_W     = 32
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_syscall,
    input  logic [31:0]      in_A,
    input  logic [31:0]      in_B,
    input  logic             in_go,
    output logic             out_pc_en,
    output logic             out_halted,
    output logic [31:0]      out_led,
    output logic [CNT_W-1:0] out_icount,
    output logic [CNT_W-1:0] out_sccount
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALT   = 2'd1,
        ST_RESUME = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             go_s1_q, go_s2_q, go_s3_q;
    logic             go_rise;
    logic             is_run;
    logic             hit_halt, hit_disp;
    logic             pc_en;
    logic [31:0]      led_q, led_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    logic [CNT_W-1:0] sccount_q, sccount_d;

    // Third flop only serves edge detection, so a held button pulses once.
    assign go_rise  = go_s2_q & ~go_s3_q;

    assign is_run   = (state_q == ST_RUN);
    assign hit_halt = is_run & in_syscall & (in_A == HALT_CODE);
    assign hit_disp = is_run & in_syscall & (in_A == DISP_CODE);

    always_comb begin
        state_d = state_q;
        pc_en   = 1'b1;
        case (state_q)
            ST_RUN: begin
                // The halting syscall stays frozen; it retires in RESUME.
                pc_en = ~hit_halt;
                if (hit_halt) state_d = ST_HALT;
            end
            ST_HALT: begin
                pc_en = 1'b0;
                if (go_rise) state_d = ST_RESUME;
            end
            ST_RESUME: begin
                // in_syscall ignored here so the frozen halt cannot re-fire.
                pc_en   = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                pc_en   = 1'b1;
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        led_d     = hit_disp ? in_B : led_q;
        sccount_d = (is_run & in_syscall) ? sccount_q + CNT_ONE : sccount_q;
        icount_d  = pc_en ? icount_q + CNT_ONE : icount_q;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= ST_RUN;
            go_s1_q   <= 1'b0;
            go_s2_q   <= 1'b0;
            go_s3_q   <= 1'b0;
            led_q     <= '0;
            icount_q  <= '0;
            sccount_q <= '0;
        end else begin
            state_q   <= state_d;
            go_s1_q   <= in_go;
            go_s2_q   <= go_s1_q;
            go_s3_q   <= go_s2_q;
            led_q     <= led_d;
            icount_q  <= icount_d;
            sccount_q <= sccount_d;
        end
    end

    // Reset forces the gate open even if a halting syscall is on the bus.
    assign out_pc_en   = in_rst | pc_en;
    assign out_halted  = (state_q == ST_HALT);
    assign out_led     = led_q;
    assign out_icount  = icount_q;
    assign out_sccount = sccount_q;

endmodule
